multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Main sequencer for the multicycle RV32I subset core: lw, sw, beq, jal, I-type ALU, R-type ALU. It replaces the single-cycle decoder. Each instruction steps through FETCH/DECODE/EXECUTE/WRITEBACK states over one shared ALU and one shared instruction/data memory. A memory ready handshake stretches memory states, and a retired-instruction counter is kept.

Parameters:
CNT_W, 32, width of the retired-instruction counter
RESET_PC_WAIT, 0, number of idle cycles in FETCH after reset release before the first fetch (0..15)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
opcode  input  7  instr[6:0] from the instruction register
zero  input  1  ALU zero flag
memReady  input  1  memory completes the current access this cycle
pcWrite  output  1  PC register enable
adrSrc  output  1  memory address select: 0=PC, 1=ALUOut
memWrite  output  1  memory write strobe
irWrite  output  1  instruction register and oldPC enable
resultSrc  output  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
aluSrcA  output  2  ALU A operand: 00=PC, 01=oldPC, 10=rs1
aluSrcB  output  2  ALU B operand: 00=rs2, 01=imm, 10=constant 4
aluOp  output  2  00=add, 01=sub, 10=funct-decoded
immSrc  output  2  immediate format: 00=I, 01=S, 10=B, 11=J
regWrite  output  1  register file write enable
state  output  4  current state code, for debug
instrRetired  output  CNT_W  count of completed instructions

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0):
  - state=FETCH (0); instrRetired=0; idle counter loaded with RESET_PC_WAIT.
  - All enables 0 during reset: pcWrite, memWrite, irWrite, regWrite.
- Registered state, Moore outputs, except:
  - pcWrite = pcUpdate | (branch & zero).
  - immSrc is decoded combinationally from opcode in every state.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. Codes 11-15 are unused and go to FETCH next cycle.
- Outputs not listed for a state are 0.
- FETCH:
  - Outputs: adrSrc=0, aluSrcA=00, aluSrcB=10, resultSrc=10.
  - While the idle counter is nonzero: decrement it, no strobes.
  - Otherwise irWrite=memReady and pcUpdate=memReady.
  - Go to DECODE only when memReady=1; else hold FETCH.
- DECODE:
  - Outputs: aluSrcA=01, aluSrcB=01 (precompute branch target).
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; other -> see Optional Feature.
- MEMADR:
  - Outputs: aluSrcA=10, aluSrcB=01.
  - Next: lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD:
  - Outputs: adrSrc=1.
  - Hold until memReady, then -> MEMWB.
- MEMWB: resultSrc=01, regWrite=1 -> FETCH.
- MEMWRITE:
  - Outputs: adrSrc=1; memWrite=1 held every cycle until memReady=1.
  - Then -> FETCH.
- EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10 -> ALUWB.
- EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10 -> ALUWB.
- ALUWB: resultSrc=00, regWrite=1 -> FETCH.
- BEQ:
  - Outputs: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1.
  - Next: FETCH.
- JAL:
  - Outputs: aluSrcA=01, aluSrcB=10, resultSrc=00, pcUpdate=1.
  - Next: ALUWB (writes PC+4 to rd).
- Latencies with memReady=1: lw 5 cycles, sw 4, R/I 4, beq 3, jal 4.
- instrRetired:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Wraps modulo 2^CNT_W.
  - Not incremented on an illegal-opcode exit.
- opcode is sampled only in DECODE and MEMADR; the IR is stable there because irWrite=0.
- reset_n falling mid-instruction aborts immediately: all strobes drop asynchronously, no partial write.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE goes to state TRAP (11).
  - Adds output illegalInstr, asserted in TRAP.
  - TRAP holds all strobes 0 and sticks until reset.
- Undefined:
  - An unknown opcode in DECODE returns to FETCH (NOP, not counted).
  - No illegalInstr port.

Test Plan:
- Release reset with RESET_PC_WAIT=2, memReady=1 -> no irWrite for 2 cycles; irWrite=pcWrite=1 in cycle 3; state 0->1 next cycle.
- add (0110011), memReady=1 -> states 0,1,6,8,0; regWrite=1 only in state 8; instrRetired 0->1.
- lw with memReady low for 3 cycles in MEMREAD -> state 3 held 4 cycles; then MEMWB with resultSrc=01 and regWrite=1.
- sw, memReady low 2 cycles -> memWrite=1 for exactly 3 consecutive cycles; no regWrite.
- beq, zero=1 then zero=0 -> pcWrite=1 in BEQ only when zero=1; both retire, count +2.
- Opcode 1111111 -> with ILLEGAL_TRAP_EN: state 11, illegalInstr=1, stuck until reset_n=0. Without it: back to state 0 and count unchanged.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm_if
// Brief    : Control/status bundle between the multicycle sequencer and the
//            datapath. The illegalInstr signal exists only with ILLEGAL_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             zero;
    logic             memReady;
    logic             pcWrite;
    logic             adrSrc;
    logic             memWrite;
    logic             irWrite;
    logic [1:0]       resultSrc;
    logic [1:0]       aluSrcA;
    logic [1:0]       aluSrcB;
    logic [1:0]       aluOp;
    logic [1:0]       immSrc;
    logic             regWrite;
    logic [3:0]       state;
    logic [CNT_W-1:0] instrRetired;
`ifdef ILLEGAL_TRAP_EN
    logic             illegalInstr;

    modport master (
        input  opcode, zero, memReady,
        output pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
               aluOp, immSrc, regWrite, state, instrRetired, illegalInstr
    );
    modport slave (
        output opcode, zero, memReady,
        input  pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
               aluOp, immSrc, regWrite, state, instrRetired, illegalInstr
    );
`else
    modport master (
        input  opcode, zero, memReady,
        output pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
               aluOp, immSrc, regWrite, state, instrRetired
    );
    modport slave (
        output opcode, zero, memReady,
        input  pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
               aluOp, immSrc, regWrite, state, instrRetired
    );
`endif
endinterface
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm
// Brief    : Main sequencer of the multicycle RV32I subset core (lw, sw, beq,
//            jal, I/R ALU) with memory-ready stalls and a retired counter.
//            Optional macro ILLEGAL_TRAP_EN: unknown opcodes lock into TRAP.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
    parameter int CNT_W         = 32,
    parameter int RESET_PC_WAIT = 0
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    multicycle_control_fsm_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] c_op_lw  = 7'b0000011;
    localparam logic [6:0] c_op_sw  = 7'b0100011;
    localparam logic [6:0] c_op_r   = 7'b0110011;
    localparam logic [6:0] c_op_i   = 7'b0010011;
    localparam logic [6:0] c_op_beq = 7'b1100011;
    localparam logic [6:0] c_op_jal = 7'b1101111;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_idle;
    logic [CNT_W-1:0] r_retired;

    logic       w_pcupdate;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regwrite;
    logic       w_adrsrc;
    logic       w_retire;
    logic [1:0] w_resultsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_idle    <= 4'(RESET_PC_WAIT);
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && r_idle != 4'd0) begin
                r_idle <= r_idle - 4'd1;
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    always_comb begin
        w_next      = S_FETCH;
        w_pcupdate  = 1'b0;
        w_branch    = 1'b0;
        w_irwrite   = 1'b0;
        w_memwrite  = 1'b0;
        w_regwrite  = 1'b0;
        w_adrsrc    = 1'b0;
        w_retire    = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        w_aluop     = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                // The post-reset idle window holds FETCH with no strobes.
                if (r_idle != 4'd0) begin
                    w_next = S_FETCH;
                end else begin
                    w_irwrite  = bus.memReady;
                    w_pcupdate = bus.memReady;
                    w_next     = bus.memReady ? S_DECODE : S_FETCH;
                end
            end
            S_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
                case (bus.opcode)
                    c_op_lw, c_op_sw: w_next = S_MEMADR;
                    c_op_r:           w_next = S_EXECUTER;
                    c_op_i:           w_next = S_EXECUTEI;
                    c_op_beq:         w_next = S_BEQ;
                    c_op_jal:         w_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:          w_next = S_TRAP;
`else
                    default:          w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_next    = (bus.opcode == c_op_sw) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
                w_next   = bus.memReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
                w_retire    = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
                w_retire   = bus.memReady;
                w_next     = bus.memReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_BEQ: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b01;
                w_branch  = 1'b1;
                w_retire  = 1'b1;
            end
            S_JAL: begin
                w_alusrca  = 2'b01;
                w_alusrcb  = 2'b10;
                w_pcupdate = 1'b1;
                w_next     = S_ALUWB;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                w_next = S_TRAP;
            end
`endif
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Strobes are gated by reset_n so an abort drops them without waiting for a clock.
    assign bus.pcWrite   = reset_n & (w_pcupdate | (w_branch & bus.zero));
    assign bus.irWrite   = reset_n & w_irwrite;
    assign bus.memWrite  = reset_n & w_memwrite;
    assign bus.regWrite  = reset_n & w_regwrite;
    assign bus.adrSrc    = w_adrsrc;
    assign bus.resultSrc = w_resultsrc;
    assign bus.aluSrcA   = w_alusrca;
    assign bus.aluSrcB   = w_alusrcb;
    assign bus.aluOp     = w_aluop;
    assign bus.state     = r_state;
    assign bus.instrRetired = r_retired;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegalInstr = (r_state == S_TRAP);
`endif

    always_comb begin
        case (bus.opcode)
            c_op_sw:  bus.immSrc = 2'b01;
            c_op_beq: bus.immSrc = 2'b10;
            c_op_jal: bus.immSrc = 2'b11;
            default:  bus.immSrc = 2'b00;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_fsm
// Brief    : Directed plus random instruction streams against a per-instruction
//            state-path model of the multicycle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;
    localparam int CNT_W = 4;
    localparam int WAIT  = 2;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] strobes;   // pcWrite, irWrite, memWrite, regWrite
        logic [10:0] muxes;    // adrSrc, resultSrc, aluSrcA, aluSrcB, aluOp, immSrc
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   retired  = 0;

    multicycle_control_fsm_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control_fsm #(
        .CNT_W         (CNT_W),
        .RESET_PC_WAIT (WAIT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected outputs of one cycle, straight from the per-state output table.
    function automatic exp_t model(input int st, input bit mr, input bit z,
                                   input bit idle, input logic [6:0] op);
        logic       pcw = 1'b0, irw = 1'b0, mw = 1'b0, rw = 1'b0, adr = 1'b0;
        logic [1:0] rs = 2'd0, a = 2'd0, b = 2'd0, alu = 2'd0, imm = 2'd0;
        exp_t       e;
        case (st)
            0:  begin rs = 2'd2; b = 2'd2; if (!idle) begin irw = mr; pcw = mr; end end
            1:  begin a = 2'd1; b = 2'd1; end
            2:  begin a = 2'd2; b = 2'd1; end
            3:  adr = 1'b1;
            4:  begin rs = 2'd1; rw = 1'b1; end
            5:  begin adr = 1'b1; mw = 1'b1; end
            6:  begin a = 2'd2; alu = 2'd2; end
            7:  begin a = 2'd2; b = 2'd1; alu = 2'd2; end
            8:  rw = 1'b1;
            9:  begin a = 2'd2; alu = 2'd1; pcw = z; end
            10: begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
            default: ;
        endcase
        imm = (op == OP_SW) ? 2'd1 : (op == OP_BEQ) ? 2'd2 : (op == OP_JAL) ? 2'd3 : 2'd0;
        e.st      = 4'(st);
        e.strobes = {pcw, irw, mw, rw};
        e.muxes   = {adr, rs, a, b, alu, imm};
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] obs_strobes();
        return {bus.pcWrite, bus.irWrite, bus.memWrite, bus.regWrite};
    endfunction

    // Drive one cycle's inputs just after a falling edge, check, advance a cycle.
    task automatic step(input int st, input bit mr, input bit z, input bit idle);
        exp_t e;
        bus.memReady = mr;
        bus.zero     = z;
        #1;
        e = model(st, mr, z, idle, bus.opcode);
        check("state", 32'(bus.state), 32'(e.st));
        check("strobes", 32'(obs_strobes()), 32'(e.strobes));
        check("muxes", 32'({bus.adrSrc, bus.resultSrc, bus.aluSrcA, bus.aluSrcB,
                            bus.aluOp, bus.immSrc}), 32'(e.muxes));
        check("retired", 32'(bus.instrRetired), 32'(retired % (1 << CNT_W)));
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [6:0] op, input int fst, input int mst, input bit z);
        bit legal = 1'b1;
        bus.opcode = op;
        repeat (fst) step(0, 1'b0, rb(), 1'b0);
        step(0, 1'b1, rb(), 1'b0);
        step(1, rb(), rb(), 1'b0);
        case (op)
            OP_LW: begin
                step(2, rb(), rb(), 1'b0);
                repeat (mst) step(3, 1'b0, rb(), 1'b0);
                step(3, 1'b1, rb(), 1'b0);
                step(4, rb(), rb(), 1'b0);
            end
            OP_SW: begin
                step(2, rb(), rb(), 1'b0);
                repeat (mst) step(5, 1'b0, rb(), 1'b0);
                step(5, 1'b1, rb(), 1'b0);
            end
            OP_R:   begin step(6, rb(), rb(), 1'b0);  step(8, rb(), rb(), 1'b0); end
            OP_I:   begin step(7, rb(), rb(), 1'b0);  step(8, rb(), rb(), 1'b0); end
            OP_BEQ: step(9, rb(), z, 1'b0);
            OP_JAL: begin step(10, rb(), rb(), 1'b0); step(8, rb(), rb(), 1'b0); end
            default: legal = 1'b0;
        endcase
        if (legal) retired = retired + 1;
    endtask

    task automatic reset_and_release();
        reset_n = 1'b0;
        bus.memReady = 1'b1;
        @(negedge clk);
        #1;
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_strobes", 32'(obs_strobes()), 32'd0);
        check("rst_retired", 32'(bus.instrRetired), 32'd0);
        retired = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (WAIT) step(0, 1'b1, rb(), 1'b1);
    endtask

    initial begin
        logic [6:0] ops [7];
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_BAD};
        reset_n      = 1'b0;
        bus.opcode   = OP_R;
        bus.zero     = 1'b0;
        bus.memReady = 1'b1;
        @(negedge clk);
        reset_and_release();

        // Directed sequences
        run_instr(OP_R, 0, 0, 1'b0);
        run_instr(OP_LW, 1, 3, 1'b0);
        run_instr(OP_SW, 0, 2, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b1);
        run_instr(OP_BEQ, 0, 0, 1'b0);
        run_instr(OP_JAL, 2, 0, 1'b0);
        run_instr(OP_I, 0, 0, 1'b0);
`ifndef ILLEGAL_TRAP_EN
        run_instr(OP_BAD, 0, 0, 1'b0);
`endif

        // Random stream; the 4-bit counter wraps several times
        for (int n = 0; n < 300; n++) begin
            int k;
`ifdef ILLEGAL_TRAP_EN
            k = $urandom_range(0, 5);
`else
            k = $urandom_range(0, 6);
`endif
            run_instr(ops[k], $urandom_range(0, 2), $urandom_range(0, 3), rb());
        end

        // Abort a store mid-access: memWrite must drop at once
        bus.opcode = OP_SW;
        step(0, 1'b1, 1'b0, 1'b0);
        step(1, 1'b1, 1'b0, 1'b0);
        step(2, 1'b1, 1'b0, 1'b0);
        bus.memReady = 1'b0;
        #2;
        check("pre_abort_memWrite", 32'(bus.memWrite), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_strobes", 32'(obs_strobes()), 32'd0);
        check("abort_state", 32'(bus.state), 32'd0);
        @(negedge clk);
        reset_and_release();
        run_instr(OP_R, 0, 0, 1'b0);

`ifdef ILLEGAL_TRAP_EN
        bus.opcode = OP_BAD;
        step(0, 1'b1, 1'b0, 1'b0);
        step(1, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step(11, 1'b1, rb(), 1'b0);
            check("illegalInstr", 32'(bus.illegalInstr), 32'd1);
        end
        reset_and_release();
        #1;
        check("illegal_cleared", 32'(bus.illegalInstr), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
